// File: rtl/mem_access_unit_pkg.sv
// ============================================================================
// mem_access_unit_pkg : shared width encodings, FSM states and lane helpers
// Revision 1.0
// ============================================================================
`default_nettype none

package mem_access_unit_pkg;

  localparam logic [1:0] LSW_BYTE = 2'b00;
  localparam logic [1:0] LSW_HALF = 2'b01;
  localparam logic [1:0] LSW_WORD = 2'b10;
  localparam logic [1:0] LSW_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_GNT = 2'd1,
    ST_WAIT_RSP = 2'd2
  } state_e;

  function automatic logic [3:0] byte_enables(input logic [1:0] width, input logic [1:0] addr);
    logic [3:0] be;
    case (width)
      LSW_BYTE: be = 4'b0001 << addr;
      LSW_HALF: be = 4'b0011 << {addr[1], 1'b0};
      default:  be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_lanes(input logic [1:0] width, input logic [31:0] d);
    logic [31:0] w;
    case (width)
      LSW_BYTE: w = {4{d[7:0]}};
      LSW_HALF: w = {2{d[15:0]}};
      default:  w = d;
    endcase
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_access_unit_load_align.sv
// ============================================================================
// mem_access_unit_load_align : read-lane select with sign/zero extension
// Revision 1.0
// ============================================================================
`default_nettype none

module mem_access_unit_load_align
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_i,
  input  logic [1:0]  width_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  logic [7:0]  w_lane_b;
  logic [15:0] w_lane_h;

  always_comb begin
    w_lane_b = rdata_i[{addr_i, 3'b000} +: 8];
    w_lane_h = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (width_i)
      LSW_BYTE: data_o = {{24{~unsigned_i & w_lane_b[7]}}, w_lane_b};
      LSW_HALF: data_o = {{16{~unsigned_i & w_lane_h[15]}}, w_lane_h};
      default:  data_o = rdata_i;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ============================================================================
// mem_access_unit : RV32I memory-stage load/store engine (req/gnt/rsp port)
// Revision 1.0
// ============================================================================
`default_nettype none

module mem_access_unit
  import mem_access_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] i_ALUResult_32,
  input  logic        i_Load_1,
  input  logic        i_Store_1,
  input  logic        i_LoadUnsigned_1,
  input  logic [1:0]  i_LoadStoreWidth_2,
  input  logic [31:0] i_StoreData_32,
  output logic [31:0] o_MemResult_32,
  output logic        o_Stall_1,
  output logic        o_Misaligned_1,
  output logic        o_DmemReq_1,
  output logic        o_DmemWe_1,
  output logic [31:0] o_DmemAddr_32,
  output logic [3:0]  o_DmemBe_4,
  output logic [31:0] o_DmemWdata_32,
  input  logic        i_DmemGnt_1,
  input  logic        i_DmemRvalid_1,
  input  logic [31:0] i_DmemRdata_32
);

  state_e      state_q, state_d;
  logic        w_access;
  logic        w_misaligned;
  logic        w_aligned;
  logic        w_complete;
  logic [31:0] w_load_data;

  assign w_access = i_Load_1 | i_Store_1;

  always_comb begin
    case (i_LoadStoreWidth_2)
      LSW_HALF: w_misaligned = w_access & i_ALUResult_32[0];
      LSW_WORD: w_misaligned = w_access & (i_ALUResult_32[1:0] != 2'b00);
      LSW_RSVD: w_misaligned = w_access;
      default:  w_misaligned = 1'b0;
    endcase
  end

  assign w_aligned      = w_access & ~w_misaligned;
  assign o_Misaligned_1 = w_misaligned;

  assign o_DmemReq_1    = w_aligned & (state_q != ST_WAIT_RSP);
  assign o_DmemWe_1     = o_DmemReq_1 & i_Store_1;
  assign o_DmemAddr_32  = {i_ALUResult_32[31:2], 2'b00};
  assign o_DmemBe_4     = o_DmemReq_1 ? byte_enables(i_LoadStoreWidth_2, i_ALUResult_32[1:0]) : 4'b0000;
  assign o_DmemWdata_32 = store_lanes(i_LoadStoreWidth_2, i_StoreData_32);

  // A store retires on grant; a load only on its response.
  assign w_complete = (state_q == ST_WAIT_RSP) ? (i_Load_1 & i_DmemRvalid_1)
                                               : (o_DmemReq_1 & i_Store_1 & i_DmemGnt_1);
  assign o_Stall_1  = w_aligned & ~w_complete;

  mem_access_unit_load_align u_load_align (
    .rdata_i    (i_DmemRdata_32),
    .addr_i     (i_ALUResult_32[1:0]),
    .width_i    (i_LoadStoreWidth_2),
    .unsigned_i (i_LoadUnsigned_1),
    .data_o     (w_load_data)
  );

  always_comb begin
    if (w_misaligned)  o_MemResult_32 = 32'h0;
    else if (i_Load_1) o_MemResult_32 = w_load_data;
    else               o_MemResult_32 = i_ALUResult_32;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_WAIT_GNT: begin
        if (!w_aligned)       state_d = ST_IDLE;
        else if (i_DmemGnt_1) state_d = i_Load_1 ? ST_WAIT_RSP : ST_IDLE;
        else                  state_d = ST_WAIT_GNT;
      end
      ST_WAIT_RSP: begin
        if (i_DmemRvalid_1 || !w_aligned) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

endmodule

`default_nettype wire
